// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits are served in the
// request cycle; misses issue a single-word read to the memory controller.
//
//   state | meaning
//   IDLE  | serving hits, latching the miss address on a miss
//   MISS  | iREN held on maddr until the controller drops iwait
module icache_direct #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              flush,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS];
    logic [WORD_W-1:0] maddr;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] m_tag;
    logic [IDX_W-1:0] m_idx;
    logic             lookup_hit;
    logic             start_miss;
    logic             fill;
    logic             unused_offset;

    assign req_tag = imemaddr[WORD_W-1:IDX_W+2];
    assign req_idx = imemaddr[IDX_W+1:2];
    assign m_tag   = maddr[WORD_W-1:IDX_W+2];
    assign m_idx   = maddr[IDX_W+1:2];

    // Byte offset carries no information for a word-wide fetch.
    assign unused_offset = &{1'b0, imemaddr[1:0]};

    assign lookup_hit = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
    assign start_miss = (state == IDLE) & imemREN & ~lookup_hit & ~flush;
    assign fill       = (state == MISS) & ~iwait & ~flush;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_miss) state_nx = MISS;
            MISS: if (flush || !iwait) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ihit     = lookup_hit & (state == IDLE);
        imemload = ihit ? data[req_idx] : '0;
        iREN     = (state == MISS);
        iaddr    = (state == MISS) ? maddr : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            valid <= '0;
            maddr <= '0;
        end else begin
            state <= state_nx;
            if (flush)
                valid <= '0;
            else if (fill)
                valid[m_idx] <= 1'b1;
            if (start_miss)
                maddr <= {imemaddr[WORD_W-1:2], 2'b00};
        end
    end

    // Tag/data arrays carry no reset; valid alone qualifies their contents.
    always_ff @(posedge CLK) begin
        if (nRST && fill) begin
            tags[m_idx] <= m_tag;
            data[m_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a per-cycle vector table for miss, fill,
// conflict, flush and mid-miss address changes, plus a reset-mid-miss sequence.
module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks;
    int failures;

    icache_direct #(.SETS(16), .WORD_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .flush    (flush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        flsh;
        logic        iw;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ren, input logic [31:0] addr,
                                input logic flsh, input logic iw,
                                input logic [31:0] ld, input logic e_hit,
                                input logic [31:0] e_load, input logic e_iren,
                                input logic [31:0] e_iaddr);
        vec_t v;
        v.ren = ren; v.addr = addr; v.flsh = flsh; v.iw = iw; v.ld = ld;
        v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step %0d got=%h exp=%h", nm, idx, got, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic e_hit, input logic [31:0] e_load,
                              input logic e_iren, input logic [31:0] e_iaddr);
        chk("ihit", idx, {31'd0, ihit}, {31'd0, e_hit});
        chk("imemload", idx, imemload, e_load);
        chk("iREN", idx, {31'd0, iREN}, {31'd0, e_iren});
        chk("iaddr", idx, iaddr, e_iaddr);
    endtask

    task automatic drive(input logic rst_n, input logic ren, input logic [31:0] addr,
                         input logic flsh, input logic iw, input logic [31:0] ld);
        nRST = rst_n; imemREN = ren; imemaddr = addr; flush = flsh; iwait = iw; iload = ld;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

        // cold miss on 0x40, three wait cycles, fill, then hit
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
        add(1, 32'h43,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
        add(0, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        // conflict on index 0 between 0x40 and 0x440
        add(1, 32'h440, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h440, 0, 0, 32'h22222222, 0, 32'h0,        1, 32'h440);
        add(1, 32'h440, 0, 1, 32'h0,        1, 32'h22222222, 0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 0, 32'h11111111, 0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        1, 32'h11111111, 0, 32'h0);
        add(1, 32'h440, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h440, 0, 0, 32'h22222222, 0, 32'h0,        1, 32'h440);
        add(1, 32'h440, 0, 1, 32'h0,        1, 32'h22222222, 0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 0, 32'h11111111, 0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        1, 32'h11111111, 0, 32'h0);
        // flush in MISS with iwait low: no fill, read abandoned
        add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h80,  1, 0, 32'h33333333, 0, 32'h0,        1, 32'h80);
        add(0, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 0, 32'h44444444, 0, 32'h0,        1, 32'h40);
        add(0, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        // flush in IDLE: hit still reported this cycle, nothing latched
        add(1, 32'h40,  1, 1, 32'h0,        1, 32'h44444444, 0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 0, 32'h55555555, 0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        1, 32'h55555555, 0, 32'h0);
        // request drops and address moves during a miss
        add(0, 32'h0,   1, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(0, 32'h80,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(0, 32'h80,  0, 0, 32'h66666666, 0, 32'h0,        1, 32'h40);
        add(1, 32'h40,  0, 1, 32'h0,        1, 32'h66666666, 0, 32'h0);
        add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h80,  0, 0, 32'h77777777, 0, 32'h0,        1, 32'h80);
        add(1, 32'h80,  0, 1, 32'h0,        1, 32'h77777777, 0, 32'h0);
        // second index coexists with index 0
        add(1, 32'h44,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h44,  0, 0, 32'h88888888, 0, 32'h0,        1, 32'h44);
        add(1, 32'h46,  0, 1, 32'h0,        1, 32'h88888888, 0, 32'h0);
        add(1, 32'h80,  0, 1, 32'h0,        1, 32'h77777777, 0, 32'h0);

        @(posedge CLK);
        @(posedge CLK);
        #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        #1;
        check_outs(-1, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK);
            #1;
            drive(1'b1, tbl[i].ren, tbl[i].addr, tbl[i].flsh, tbl[i].iw, tbl[i].ld);
            #1;
            check_outs(i, tbl[i].e_hit, tbl[i].e_load, tbl[i].e_iren, tbl[i].e_iaddr);
        end

        // reset mid-miss on 0x48: read abandoned, every earlier frame invalid
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
        #1; check_outs(100, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h99999999);
        #1; check_outs(101, 1'b0, 32'h0, 1'b1, 32'h48);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 32'h48, 1'b0, 1'b1, 32'h0);
        #1; check_outs(102, 1'b0, 32'h0, 1'b0, 32'h0);
        // probe with flush held so a miss is not latched
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h0);
        #1; check_outs(103, 1'b0, 32'h0, 1'b0, 32'h0);
        imemaddr = 32'h44;
        #1; check_outs(104, 1'b0, 32'h0, 1'b0, 32'h0);
        imemaddr = 32'h48;
        #1; check_outs(105, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
        #1; check_outs(106, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 32'hABCD0123);
        #1; check_outs(107, 1'b0, 32'h0, 1'b1, 32'h48);
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
        #1; check_outs(108, 1'b1, 32'hABCD0123, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
